// File: rtl/sid_bus_writer.sv
// sid_bus_writer: FIFO-buffered SID register writer with phi2 division, CS timing and chip reset.
// Build option SID_SHADOW_EN adds a 32x8 shadow of written registers (SHADOW_ADDR/SHADOW_DATA).
//
// state  | meaning
// RST    | SID_NOTRES held low for RES_CYCLES phi2 periods
// IDLE   | waiting for ph 0 with a queued write
// SETUP  | addr/data on pins, CS still high
// STROBE | CS low across the phi2 falling edge
// HOLD   | CS released, addr/data held until ph CLK_DIV/4
module sid_bus_writer #(
  parameter int CLK_DIV    = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int RES_CYCLES = 16
) (
  input  logic                            C6_CLK_8MHZ,
  input  logic                            RESET,
  input  logic                            WR_VALID,
  input  logic [4:0]                      WR_ADDR,
  input  logic [7:0]                      WR_DATA,
  output logic                            WR_READY,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] FIFO_LEVEL,
  output logic                            BUSY,
  output logic                            SID_CLK,
  output logic                            SID_NOTRES,
  output logic                            SID_NOTCS,
  output logic [4:0]                      SID_ADDR,
  output logic [7:0]                      SID_DATA
`ifdef SID_SHADOW_EN
  ,
  input  logic [4:0]                      SHADOW_ADDR,
  output logic [7:0]                      SHADOW_DATA
`endif
);

  localparam int PH_W  = $clog2(CLK_DIV);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int RC_W  = $clog2(RES_CYCLES + 1);

  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
  localparam logic [PH_W-1:0]  PH_QTR   = PH_W'(CLK_DIV / 4);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(CLK_DIV / 2);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [RC_W-1:0]  RC_LOAD  = RC_W'(RES_CYCLES - 1);

  typedef enum logic [2:0] {RST, IDLE, SETUP, STROBE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic              sid_clk_q, sid_clk_d;
  logic              notres_q, notres_d;
  logic              notcs_q, notcs_d;
  logic [4:0]        addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [RC_W-1:0]   res_cnt_q, res_cnt_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              wr_ready_q, wr_ready_d;
  logic              busy_q, busy_d;
  logic              push, pop;
  logic [12:0]       fifo_mem [FIFO_DEPTH];

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q + PH_ONE;
    sid_clk_d = (ph_d >= PH_HALF);
    notres_d  = notres_q;
    notcs_d   = notcs_q;
    addr_d    = addr_q;
    data_d    = data_q;
    res_cnt_d = res_cnt_q;
    pop       = 1'b0;

    // Every phase compare looks at the phase the flops are about to enter.
    case (state_q)
      RST: begin
        if (ph_d == '0) begin
          if (res_cnt_q == '0) begin
            notres_d = 1'b1;
            state_d  = IDLE;
          end else begin
            res_cnt_d = res_cnt_q - RC_W'(1);
          end
        end
      end
      IDLE: begin
        if (ph_d == '0 && level_q != '0) begin
          pop              = 1'b1;
          {addr_d, data_d} = fifo_mem[rd_ptr_q];
          state_d          = SETUP;
        end
      end
      SETUP: begin
        if (ph_d == PH_QTR) begin
          notcs_d = 1'b0;
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (ph_d == PH_ONE) begin
          notcs_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ph_d == PH_QTR) state_d = IDLE;
      end
      default: state_d = RST;
    endcase

    push     = WR_VALID && wr_ready_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    wr_ready_d = (level_d != LVL_FULL) && (state_d != RST);
    busy_d     = (state_d != IDLE) || (level_d != '0);
  end

  always_ff @(posedge C6_CLK_8MHZ) begin
    if (push) fifo_mem[wr_ptr_q] <= {WR_ADDR, WR_DATA};
  end

  always_ff @(posedge C6_CLK_8MHZ) begin
    if (RESET) begin
      state_q    <= RST;
      ph_q       <= '0;
      sid_clk_q  <= 1'b0;
      notres_q   <= 1'b0;
      notcs_q    <= 1'b1;
      addr_q     <= '0;
      data_q     <= '0;
      res_cnt_q  <= RC_LOAD;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ready_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      sid_clk_q  <= sid_clk_d;
      notres_q   <= notres_d;
      notcs_q    <= notcs_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      res_cnt_q  <= res_cnt_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign WR_READY   = wr_ready_q;
  assign FIFO_LEVEL = level_q;
  assign BUSY       = busy_q;
  assign SID_CLK    = sid_clk_q;
  assign SID_NOTRES = notres_q;
  assign SID_NOTCS  = notcs_q;
  assign SID_ADDR   = addr_q;
  assign SID_DATA   = data_q;

`ifdef SID_SHADOW_EN
  logic [7:0] shadow_q [32];
  logic [7:0] shadow_d [32];
  logic [7:0] shadow_data_q, shadow_data_d;

  // The shadow follows the chip: it only changes when CS is released on a completed strobe.
  always_comb begin
    shadow_d = shadow_q;
    if (state_q == STROBE && state_d == HOLD) shadow_d[addr_q] = data_q;
    shadow_data_d = shadow_q[SHADOW_ADDR];
  end

  always_ff @(posedge C6_CLK_8MHZ) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
      shadow_data_q <= '0;
    end else begin
      shadow_q      <= shadow_d;
      shadow_data_q <= shadow_data_d;
    end
  end

  assign SHADOW_DATA = shadow_data_q;
`endif

endmodule

// File: tb/tb_sid_bus_writer.sv
`timescale 1ns/1ps
// tb_sid_bus_writer: vector table plus scoreboard checks of SID bus timing, FIFO and reset sequence.
module tb_sid_bus_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic [3:0] fifo_level;
  logic       busy, sid_clk, sid_notres, sid_notcs;
  logic [4:0] sid_addr;
  logic [7:0] sid_data;
`ifdef SID_SHADOW_EN
  logic [4:0] shadow_addr = '0;
  logic [7:0] shadow_data;
`endif

  always #5 clk = ~clk;

  sid_bus_writer dut (
    .C6_CLK_8MHZ (clk),
    .RESET       (rst),
    .WR_VALID    (wr_valid),
    .WR_ADDR     (wr_addr),
    .WR_DATA     (wr_data),
    .WR_READY    (wr_ready),
    .FIFO_LEVEL  (fifo_level),
    .BUSY        (busy),
    .SID_CLK     (sid_clk),
    .SID_NOTRES  (sid_notres),
    .SID_NOTCS   (sid_notcs),
    .SID_ADDR    (sid_addr),
    .SID_DATA    (sid_data)
`ifdef SID_SHADOW_EN
    ,
    .SHADOW_ADDR (shadow_addr),
    .SHADOW_DATA (shadow_data)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [2:0]  ph_m = 3'd0;
  logic        rst_seen = 1'b1;
  logic [12:0] sb [$];
  int          cs_start_q [$];
  int          strobes = 0;
  int          last_rel = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference phase: free-running mod-8 count since the last reset edge.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
    ph_m     <= rst ? 3'd0 : ph_m + 3'd1;
  end

  initial begin : mon
    int          cs_cnt;
    logic [4:0]  ca;
    logic [7:0]  cd;
    logic [12:0] e;
    cs_cnt = 0; ca = '0; cd = '0;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        cs_cnt = 0;
      end else begin
        chk("sid_clk_phase", sid_clk, ph_m >= 3'd4);
        if (!sid_notcs) begin
          if (cs_cnt == 0) begin
            ca = sid_addr; cd = sid_data;
            chk("cs_fall_ph", ph_m, 2);
            cs_start_q.push_back(cyc);
          end else begin
            chk("addr_stable", sid_addr, ca);
            chk("data_stable", sid_data, cd);
          end
          cs_cnt++;
        end else if (cs_cnt != 0) begin
          chk("cs_low_len", cs_cnt, 7);
          chk("cs_rel_ph", ph_m, 1);
          chk("sb_has_entry", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("strobe_addr", ca, e[12:8]);
            chk("strobe_data", cd, e[7:0]);
          end
          strobes++;
          last_rel = cyc;
          cs_cnt = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ph(input int p);
    for (int i = 0; i < 8 && ph_m != 3'(p); i++) step();
    chk("ph_align", ph_m, p);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) step();
    chk("busy_low", busy, 0);
  endtask

  task automatic push(input logic [4:0] a, input logic [7:0] d, output int stalls);
    logic acc;
    acc = 1'b0; stalls = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    for (int i = 0; i < 64 && !acc; i++) begin
      acc = wr_ready;
      step();
      if (acc) sb.push_back({a, d});
      else stalls++;
    end
    chk("push_accepted", acc, 1);
  endtask

  task automatic do_reset();
    int   n;
    logic early;
    rst = 1'b1; wr_valid = 1'b0;
    repeat (3) step();
    sb.delete();
    chk("rst_notres", sid_notres, 0);
    chk("rst_notcs", sid_notcs, 1);
    chk("rst_sid_clk", sid_clk, 0);
    chk("rst_addr", sid_addr, 0);
    chk("rst_data", sid_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", wr_ready, 0);
    chk("rst_busy", busy, 1);
    rst = 1'b0; n = 0; early = 1'b0;
    while (n < 300 && !sid_notres) begin
      step();
      n++;
      if (!sid_notres) early = early | wr_ready;
    end
    chk("notres_low_clks", n, 128);
    chk("ready_before_notres", early, 0);
    chk("ready_with_notres", wr_ready, 1);
    chk("busy_after_reset", busy, 0);
  endtask

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
    int         exp_level;
    logic       exp_ready;
  } vec_t;

  initial begin : main
    vec_t vecs [8];
    int   bp_exp [6];
    int   st, tot_st, s0, n0;
    logic ready_now;

    for (int i = 0; i < 8; i++) begin
      vecs[i].addr      = 5'(i);
      vecs[i].data      = 8'(i + 1);
      vecs[i].exp_level = i + 1;
      vecs[i].exp_ready = (i < 7);
    end
    bp_exp = '{1, 2, 3, 4, 5, 5};

    do_reset();

    // Single write: pins change on the next ph0, not before.
    wait_ph(3);
    push(5'h18, 8'h1f, st);
    wr_valid = 1'b0;
    repeat (3) step();
    chk("lat_pre_addr", sid_addr, 5'h00);
    step();
    chk("lat_addr", sid_addr, 5'h18);
    chk("lat_data", sid_data, 8'h1f);
    chk("lat_notcs", sid_notcs, 1);
    wait_idle(64);

    // Push landing on the ph0 edge waits a full period.
    wait_ph(7);
    push(5'h05, 8'ha5, st);
    wr_valid = 1'b0;
    chk("nobypass_old_addr", sid_addr, 5'h18);
    chk("nobypass_old_data", sid_data, 8'h1f);
    repeat (8) step();
    chk("nobypass_addr", sid_addr, 5'h05);
    chk("nobypass_data", sid_data, 8'ha5);
    wait_idle(64);

    // Burst of 8 fills the FIFO before the first pop.
    cs_start_q.delete();
    wait_ph(7);
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = vecs[i].addr; wr_data = vecs[i].data;
      ready_now = wr_ready;
      step();
      if (ready_now) sb.push_back({vecs[i].addr, vecs[i].data});
      chk("burst_ready_in", ready_now, 1);
      chk("burst_level", fifo_level, vecs[i].exp_level);
      chk("burst_ready_out", wr_ready, vecs[i].exp_ready);
      chk("burst_busy", busy, 1);
    end
    wr_valid = 1'b0;
    wait_idle(200);
    chk("busy_fall_after_hold", cyc - last_rel, 1);
    chk("burst_strobes", cs_start_q.size(), 8);
    for (int i = 1; i < cs_start_q.size(); i++)
      chk("burst_spacing", cs_start_q[i] - cs_start_q[i-1], 16);

    // Backpressure with 12 writes; 6th push coincides with the first pop.
    wait_ph(2);
    n0 = strobes; tot_st = 0;
    for (int k = 0; k < 12; k++) begin
      push(5'(8 + k), 8'(8'ha0 + k), st);
      tot_st += st;
      if (k < 6) chk("bp_level", fifo_level, bp_exp[k]);
    end
    wr_valid = 1'b0;
    chk("bp_stalled", tot_st > 0, 1);
    wait_idle(400);
    chk("bp_all_issued", strobes - n0, 12);
    chk("bp_sb_empty", sb.size(), 0);

    // Reset during STROBE with 3 queued.
    for (int k = 0; k < 4; k++) push(5'(5'h10 + k), 8'(8'h50 + k), st);
    wr_valid = 1'b0;
    for (int i = 0; i < 40 && sid_notcs; i++) step();
    chk("mid_strobe_seen", sid_notcs, 0);
    chk("mid_level", fifo_level, 3);
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("abort_notcs", sid_notcs, 1);
    chk("abort_level", fifo_level, 0);
    chk("abort_notres", sid_notres, 0);
    s0 = strobes;
    do_reset();
    chk("no_strobe_in_reset", strobes - s0, 0);
    push(5'h1f, 8'h3c, st);
    wr_valid = 1'b0;
    wait_idle(64);
    chk("post_reset_strobe", strobes - s0, 1);

`ifdef SID_SHADOW_EN
    push(5'h04, 8'h11, st);
    wr_valid = 1'b0;
    wait_idle(64);
    shadow_addr = 5'h04;
    step(); step();
    chk("shadow_first", shadow_data, 8'h11);
    push(5'h04, 8'h10, st);
    wr_valid = 1'b0;
    wait_idle(64);
    step();
    chk("shadow_second", shadow_data, 8'h10);
    shadow_addr = 5'h1f;
    step(); step();
    chk("shadow_unwritten", shadow_data, 8'h00);
`endif

    chk("sb_final_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
